// File: rtl/lc3_pkg.sv
// Shared LC-3 control definitions: FSM state encoding, opcodes and datapath
// select encodings used by the control FSM and anything that decodes its outputs.
package lc3_pkg;

  typedef enum logic [4:0] {
    ST_HALTED,
    ST_FETCH1,
    ST_FETCH2,
    ST_FETCH3,
    ST_DECODE,
    ST_ADD,
    ST_AND,
    ST_NOT,
    ST_BR,
    ST_BR_TAKEN,
    ST_JMP,
    ST_JSR,
    ST_JSR_R7,
    ST_LDR_ADDR,
    ST_LDR_READ,
    ST_LDR_LOAD,
    ST_STR_ADDR,
    ST_STR_DATA,
    ST_STR_WRITE,
    ST_PAUSE1,
    ST_PAUSE2
  } state_t;

  // Opcodes (IR[15:12])
  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  // PC mux
  localparam logic [1:0] PCSEL_INC   = 2'b00;
  localparam logic [1:0] PCSEL_BUS   = 2'b01;
  localparam logic [1:0] PCSEL_ADDER = 2'b10;

  // ALU function
  localparam logic [1:0] ALUK_ADD   = 2'b00;
  localparam logic [1:0] ALUK_AND   = 2'b01;
  localparam logic [1:0] ALUK_NOT   = 2'b10;
  localparam logic [1:0] ALUK_PASSA = 2'b11;

  // Address adder operands
  localparam logic [1:0] ADDR2_ZERO   = 2'b00;
  localparam logic [1:0] ADDR2_SEXT6  = 2'b01;
  localparam logic [1:0] ADDR2_SEXT9  = 2'b10;
  localparam logic [1:0] ADDR2_SEXT11 = 2'b11;
  localparam logic       ADDR1_PC     = 1'b0;
  localparam logic       ADDR1_SR1    = 1'b1;

  // Register file port selects
  localparam logic DRMUX_IR_11_9  = 1'b0;
  localparam logic DRMUX_R7       = 1'b1;
  localparam logic SR1MUX_IR_11_9 = 1'b0;
  localparam logic SR1MUX_IR_8_6  = 1'b1;

  // States that drive the external memory and are timed by the wait counter
  function automatic logic is_mem_state(state_t s);
    return (s == ST_FETCH2) || (s == ST_LDR_READ) || (s == ST_STR_WRITE);
  endfunction

endpackage

// File: rtl/lc3_control_fsm_mem_wait_timer.sv
// Memory access wait counter: loaded with MEM_WAIT-1 when a memory state is
// entered, counts down once per cycle and parks at zero (no wraparound).
module mem_wait_timer #(
  parameter int MEM_WAIT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic done
);

  logic [2:0] count_reg;

  // Load on memory-state entry, otherwise count down and hold at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= 3'd0;
    end else if (load) begin
      count_reg <= 3'(MEM_WAIT - 1);
    end else if (count_reg != 3'd0) begin
      count_reg <= count_reg - 3'd1;
    end
  end

  // Final wait cycle of the current access
  always_comb begin
    done = (count_reg == 3'd0);
  end

endmodule

// File: rtl/lc3_control_fsm.sv
// LC-3 subset control unit: fetch/decode/execute FSM producing datapath
// load strobes, bus gates, mux selects and active-low memory strobes.
module lc3_control_fsm
  import lc3_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        resume,
  input  logic [15:0] ir,
  input  logic        ben,
  output logic        ld_mar,
  output logic        ld_mdr,
  output logic        ld_ir,
  output logic        ld_ben,
  output logic        ld_cc,
  output logic        ld_reg,
  output logic        ld_pc,
  output logic        ld_led,
  output logic        gate_pc,
  output logic        gate_mdr,
  output logic        gate_alu,
  output logic        gate_marmux,
  output logic [1:0]  pc_select,
  output logic [1:0]  aluk_select,
  output logic [1:0]  addr2_mux,
  output logic        addr1_mux,
  output logic        drmux_select,
  output logic        sr1mux_select,
  output logic        sr2mux_select,
  output logic        mio_en,
  output logic        mem_ce,
  output logic        mem_ub,
  output logic        mem_lb,
  output logic        mem_oe,
  output logic        mem_we
);

  state_t state_reg, state_next;
  logic   entered_reg;   // first cycle in the current state
  logic   wait_load;
  logic   wait_done;

  // Register fields live in the datapath; only the opcode and IR[5] matter here
  logic unused_ir_bits;
  assign unused_ir_bits = ^{ir[11:6], ir[4:0]};

  mem_wait_timer #(.MEM_WAIT(MEM_WAIT)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (wait_load),
    .done  (wait_done)
  );

  // State register plus a flag marking the first cycle spent in a state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_HALTED;
      entered_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      entered_reg <= (state_next != state_reg);
    end
  end

  // Next-state decode; the wait counter is armed on every memory-state entry
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_HALTED:    if (run) state_next = ST_FETCH1;
      ST_FETCH1:    state_next = ST_FETCH2;
      ST_FETCH2:    if (wait_done) state_next = ST_FETCH3;
      ST_FETCH3:    state_next = ST_DECODE;
      ST_DECODE: begin
        case (ir[15:12])
          OP_ADD:   state_next = ST_ADD;
          OP_AND:   state_next = ST_AND;
          OP_NOT:   state_next = ST_NOT;
          OP_BR:    state_next = ST_BR;
          OP_JMP:   state_next = ST_JMP;
          OP_JSR:   state_next = ST_JSR;
          OP_LDR:   state_next = ST_LDR_ADDR;
          OP_STR:   state_next = ST_STR_ADDR;
          OP_PAUSE: state_next = ST_PAUSE1;
          default:  state_next = ST_FETCH1;
        endcase
      end
      ST_ADD, ST_AND, ST_NOT: state_next = ST_FETCH1;
      ST_BR:        state_next = ben ? ST_BR_TAKEN : ST_FETCH1;
      ST_BR_TAKEN:  state_next = ST_FETCH1;
      ST_JMP:       state_next = ST_FETCH1;
      ST_JSR:       state_next = ST_JSR_R7;
      ST_JSR_R7:    state_next = ST_FETCH1;
      ST_LDR_ADDR:  state_next = ST_LDR_READ;
      ST_LDR_READ:  if (wait_done) state_next = ST_LDR_LOAD;
      ST_LDR_LOAD:  state_next = ST_FETCH1;
      ST_STR_ADDR:  state_next = ST_STR_DATA;
      ST_STR_DATA:  state_next = ST_STR_WRITE;
      ST_STR_WRITE: if (wait_done) state_next = ST_FETCH1;
      ST_PAUSE1:    if (resume) state_next = ST_PAUSE2;
      ST_PAUSE2:    if (!resume) state_next = ST_FETCH1;
      default:      state_next = ST_HALTED;
    endcase
    wait_load = is_mem_state(state_next) && (state_next != state_reg);
  end

  // Moore output decode; everything inactive unless the state asserts it
  always_comb begin
    ld_mar = 1'b0; ld_mdr = 1'b0; ld_ir = 1'b0; ld_ben = 1'b0;
    ld_cc = 1'b0; ld_reg = 1'b0; ld_pc = 1'b0; ld_led = 1'b0;
    gate_pc = 1'b0; gate_mdr = 1'b0; gate_alu = 1'b0; gate_marmux = 1'b0;
    pc_select = PCSEL_INC; aluk_select = ALUK_ADD;
    addr2_mux = ADDR2_ZERO; addr1_mux = ADDR1_PC;
    drmux_select = DRMUX_IR_11_9; sr1mux_select = SR1MUX_IR_11_9;
    sr2mux_select = 1'b0; mio_en = 1'b0;
    mem_ce = 1'b1; mem_oe = 1'b1; mem_we = 1'b1;
    unique case (state_reg)
      ST_FETCH1: begin
        gate_pc = 1'b1; ld_mar = 1'b1; pc_select = PCSEL_INC; ld_pc = 1'b1;
      end
      ST_FETCH2, ST_LDR_READ: begin
        mio_en = 1'b1; mem_ce = 1'b0; mem_oe = 1'b0;
        ld_mdr = wait_done;   // capture only once the read data is valid
      end
      ST_FETCH3: begin
        gate_mdr = 1'b1; ld_ir = 1'b1;
      end
      ST_DECODE: ld_ben = 1'b1;
      ST_ADD, ST_AND, ST_NOT: begin
        sr1mux_select = SR1MUX_IR_8_6;
        sr2mux_select = ir[5];
        aluk_select   = (state_reg == ST_ADD) ? ALUK_ADD :
                        (state_reg == ST_AND) ? ALUK_AND : ALUK_NOT;
        gate_alu = 1'b1; ld_reg = 1'b1; ld_cc = 1'b1;
        drmux_select = DRMUX_IR_11_9;
      end
      ST_BR_TAKEN: begin
        addr1_mux = ADDR1_PC; addr2_mux = ADDR2_SEXT9;
        pc_select = PCSEL_ADDER; ld_pc = 1'b1;
      end
      ST_JMP: begin
        addr1_mux = ADDR1_SR1; sr1mux_select = SR1MUX_IR_8_6;
        addr2_mux = ADDR2_ZERO; pc_select = PCSEL_ADDER; ld_pc = 1'b1;
      end
      ST_JSR: begin
        gate_pc = 1'b1; drmux_select = DRMUX_R7; ld_reg = 1'b1;
      end
      ST_JSR_R7: begin
        addr1_mux = ADDR1_PC; addr2_mux = ADDR2_SEXT11;
        pc_select = PCSEL_ADDER; ld_pc = 1'b1;
      end
      ST_LDR_ADDR, ST_STR_ADDR: begin
        addr1_mux = ADDR1_SR1; sr1mux_select = SR1MUX_IR_8_6;
        addr2_mux = ADDR2_SEXT6; gate_marmux = 1'b1; ld_mar = 1'b1;
      end
      ST_LDR_LOAD: begin
        gate_mdr = 1'b1; ld_reg = 1'b1; ld_cc = 1'b1;
      end
      ST_STR_DATA: begin
        sr1mux_select = SR1MUX_IR_11_9; aluk_select = ALUK_PASSA;
        gate_alu = 1'b1; ld_mdr = 1'b1; mio_en = 1'b0;
      end
      ST_STR_WRITE: begin
        mem_ce = 1'b0; mem_we = 1'b0;
      end
      ST_PAUSE1: ld_led = entered_reg;   // one pulse, however long we wait
      default: ;
    endcase
    // Byte lanes follow chip enable for full-word accesses
    mem_ub = mem_ce;
    mem_lb = mem_ce;
  end

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Directed bench for lc3_control_fsm: a per-cycle table of inputs and expected
// state/outputs, plus hand sequences for asynchronous reset and restart.
module tb_lc3_control_fsm;
  import lc3_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run = 1'b0, resume = 1'b0, ben = 1'b0;
  logic [15:0] ir = 16'h0000;
  logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
  logic gate_pc, gate_mdr, gate_alu, gate_marmux;
  logic [1:0] pc_select, aluk_select, addr2_mux;
  logic addr1_mux, drmux_select, sr1mux_select, sr2mux_select, mio_en;
  logic mem_ce, mem_ub, mem_lb, mem_oe, mem_we;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lc3_control_fsm #(.MEM_WAIT(2)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .resume(resume), .ir(ir), .ben(ben),
    .ld_mar(ld_mar), .ld_mdr(ld_mdr), .ld_ir(ld_ir), .ld_ben(ld_ben),
    .ld_cc(ld_cc), .ld_reg(ld_reg), .ld_pc(ld_pc), .ld_led(ld_led),
    .gate_pc(gate_pc), .gate_mdr(gate_mdr), .gate_alu(gate_alu),
    .gate_marmux(gate_marmux), .pc_select(pc_select),
    .aluk_select(aluk_select), .addr2_mux(addr2_mux), .addr1_mux(addr1_mux),
    .drmux_select(drmux_select), .sr1mux_select(sr1mux_select),
    .sr2mux_select(sr2mux_select), .mio_en(mio_en), .mem_ce(mem_ce),
    .mem_ub(mem_ub), .mem_lb(mem_lb), .mem_oe(mem_oe), .mem_we(mem_we)
  );

  // Output word layout:
  // ld{mar,mdr,ir,ben,cc,reg,pc,led} gate{pc,mdr,alu,marmux} pcsel aluk addr2
  // {addr1,drmux,sr1mux,sr2mux,mio} mem{ce,ub,lb,oe,we}
  localparam logic [27:0] O_IDLE = {8'b0000_0000, 4'b0000, 2'b00, 2'b00, 2'b00, 5'b00000, 5'b11111};
  localparam logic [27:0] O_F1   = {8'b1000_0010, 4'b1000, 2'b00, 2'b00, 2'b00, 5'b00000, 5'b11111};
  localparam logic [27:0] O_F2W  = {8'b0000_0000, 4'b0000, 2'b00, 2'b00, 2'b00, 5'b00001, 5'b00001};
  localparam logic [27:0] O_F2L  = {8'b0100_0000, 4'b0000, 2'b00, 2'b00, 2'b00, 5'b00001, 5'b00001};
  localparam logic [27:0] O_F3   = {8'b0010_0000, 4'b0100, 2'b00, 2'b00, 2'b00, 5'b00000, 5'b11111};
  localparam logic [27:0] O_DEC  = {8'b0001_0000, 4'b0000, 2'b00, 2'b00, 2'b00, 5'b00000, 5'b11111};
  localparam logic [27:0] O_ADD  = {8'b0000_1100, 4'b0010, 2'b00, 2'b00, 2'b00, 5'b00100, 5'b11111};
  localparam logic [27:0] O_AND  = {8'b0000_1100, 4'b0010, 2'b00, 2'b01, 2'b00, 5'b00110, 5'b11111};
  localparam logic [27:0] O_NOT  = {8'b0000_1100, 4'b0010, 2'b00, 2'b10, 2'b00, 5'b00110, 5'b11111};
  localparam logic [27:0] O_BRT  = {8'b0000_0010, 4'b0000, 2'b10, 2'b00, 2'b10, 5'b00000, 5'b11111};
  localparam logic [27:0] O_JMP  = {8'b0000_0010, 4'b0000, 2'b10, 2'b00, 2'b00, 5'b10100, 5'b11111};
  localparam logic [27:0] O_JSR  = {8'b0000_0100, 4'b1000, 2'b00, 2'b00, 2'b00, 5'b01000, 5'b11111};
  localparam logic [27:0] O_JSR7 = {8'b0000_0010, 4'b0000, 2'b10, 2'b00, 2'b11, 5'b00000, 5'b11111};
  localparam logic [27:0] O_MADR = {8'b1000_0000, 4'b0001, 2'b00, 2'b00, 2'b01, 5'b10100, 5'b11111};
  localparam logic [27:0] O_LDL  = {8'b0000_1100, 4'b0100, 2'b00, 2'b00, 2'b00, 5'b00000, 5'b11111};
  localparam logic [27:0] O_STD  = {8'b0100_0000, 4'b0010, 2'b00, 2'b11, 2'b00, 5'b00000, 5'b11111};
  localparam logic [27:0] O_STW  = {8'b0000_0000, 4'b0000, 2'b00, 2'b00, 2'b00, 5'b00000, 5'b00010};
  localparam logic [27:0] O_LED  = {8'b0000_0001, 4'b0000, 2'b00, 2'b00, 2'b00, 5'b00000, 5'b11111};

  typedef struct {
    logic        run;
    logic        resume;
    logic [15:0] ir;
    logic        ben;
    state_t      st;
    logic [27:0] out;
  } vec_t;

  vec_t vq[$];

  function automatic logic [27:0] sample();
    return {ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led,
            gate_pc, gate_mdr, gate_alu, gate_marmux,
            pc_select, aluk_select, addr2_mux,
            addr1_mux, drmux_select, sr1mux_select, sr2mux_select, mio_en,
            mem_ce, mem_ub, mem_lb, mem_oe, mem_we};
  endfunction

  task automatic add_row(input logic r, input logic c, input logic [15:0] i,
                         input logic b, input state_t s, input logic [27:0] o);
    vec_t v;
    v.run = r; v.resume = c; v.ir = i; v.ben = b; v.st = s; v.out = o;
    vq.push_back(v);
  endtask

  // FETCH2 (two wait cycles), FETCH3, DECODE; caller starts from FETCH1
  task automatic add_fetch(input logic [15:0] i, input logic b);
    add_row(1'b0, 1'b0, i, b, ST_FETCH2, O_F2W);
    add_row(1'b0, 1'b0, i, b, ST_FETCH2, O_F2L);
    add_row(1'b0, 1'b0, i, b, ST_FETCH3, O_F3);
    add_row(1'b0, 1'b0, i, b, ST_DECODE, O_DEC);
  endtask

  task automatic check_now(input string name, input state_t exp_st,
                           input logic [27:0] exp_out);
    state_t act_st;
    logic [27:0] act_out;
    act_st = dut.state_reg;
    act_out = sample();
    checks++;
    if (act_st !== exp_st) begin
      errors++;
      $display("FAIL %s state: got %s want %s", name, act_st.name(), exp_st.name());
    end
    checks++;
    if (act_out !== exp_out) begin
      errors++;
      $display("FAIL %s outputs: got %07h want %07h", name, act_out, exp_out);
    end
  endtask

  initial begin
    // Table: each row's inputs are applied before the edge, expectation after it
    add_row(1'b0, 1'b0, 16'h1042, 1'b0, ST_HALTED, O_IDLE);   // no Run: stay
    add_row(1'b1, 1'b0, 16'h1042, 1'b0, ST_FETCH1, O_F1);     // Run pulse
    add_fetch(16'h1042, 1'b0);                                // ADD R0,R1,R2
    add_row(1'b0, 1'b0, 16'h1042, 1'b0, ST_ADD, O_ADD);
    add_row(1'b0, 1'b0, 16'h1042, 1'b0, ST_FETCH1, O_F1);
    add_fetch(16'h0E05, 1'b1);                                // BRnzp taken
    add_row(1'b0, 1'b0, 16'h0E05, 1'b1, ST_BR, O_IDLE);
    add_row(1'b0, 1'b0, 16'h0E05, 1'b1, ST_BR_TAKEN, O_BRT);
    add_row(1'b0, 1'b0, 16'h0E05, 1'b1, ST_FETCH1, O_F1);
    add_fetch(16'h0E05, 1'b0);                                // BR not taken
    add_row(1'b0, 1'b0, 16'h0E05, 1'b0, ST_BR, O_IDLE);
    add_row(1'b0, 1'b0, 16'h0E05, 1'b0, ST_FETCH1, O_F1);
    add_fetch(16'h7242, 1'b0);                                // STR
    add_row(1'b0, 1'b0, 16'h7242, 1'b0, ST_STR_ADDR, O_MADR);
    add_row(1'b0, 1'b0, 16'h7242, 1'b0, ST_STR_DATA, O_STD);
    add_row(1'b0, 1'b0, 16'h7242, 1'b0, ST_STR_WRITE, O_STW);
    add_row(1'b0, 1'b0, 16'h7242, 1'b0, ST_STR_WRITE, O_STW);
    add_row(1'b0, 1'b0, 16'h7242, 1'b0, ST_FETCH1, O_F1);
    add_fetch(16'h6242, 1'b0);                                // LDR
    add_row(1'b0, 1'b0, 16'h6242, 1'b0, ST_LDR_ADDR, O_MADR);
    add_row(1'b0, 1'b0, 16'h6242, 1'b0, ST_LDR_READ, O_F2W);
    add_row(1'b0, 1'b0, 16'h6242, 1'b0, ST_LDR_READ, O_F2L);
    add_row(1'b0, 1'b0, 16'h6242, 1'b0, ST_LDR_LOAD, O_LDL);
    add_row(1'b0, 1'b0, 16'h6242, 1'b0, ST_FETCH1, O_F1);
    add_fetch(16'h5020, 1'b0);                                // AND immediate
    add_row(1'b0, 1'b0, 16'h5020, 1'b0, ST_AND, O_AND);
    add_row(1'b0, 1'b0, 16'h5020, 1'b0, ST_FETCH1, O_F1);
    add_fetch(16'h927F, 1'b0);                                // NOT
    add_row(1'b0, 1'b0, 16'h927F, 1'b0, ST_NOT, O_NOT);
    add_row(1'b0, 1'b0, 16'h927F, 1'b0, ST_FETCH1, O_F1);
    add_fetch(16'hC1C0, 1'b0);                                // JMP R7
    add_row(1'b0, 1'b0, 16'hC1C0, 1'b0, ST_JMP, O_JMP);
    add_row(1'b0, 1'b0, 16'hC1C0, 1'b0, ST_FETCH1, O_F1);
    add_fetch(16'h4800, 1'b0);                                // JSR
    add_row(1'b0, 1'b0, 16'h4800, 1'b0, ST_JSR, O_JSR);
    add_row(1'b0, 1'b0, 16'h4800, 1'b0, ST_JSR_R7, O_JSR7);
    add_row(1'b0, 1'b0, 16'h4800, 1'b0, ST_FETCH1, O_F1);
    add_fetch(16'h8000, 1'b0);                                // illegal: no-op
    add_row(1'b0, 1'b0, 16'h8000, 1'b0, ST_FETCH1, O_F1);
    add_fetch(16'hD000, 1'b0);                                // PAUSE
    add_row(1'b0, 1'b0, 16'hD000, 1'b0, ST_PAUSE1, O_LED);
    add_row(1'b0, 1'b0, 16'hD000, 1'b0, ST_PAUSE1, O_IDLE);
    add_row(1'b0, 1'b1, 16'hD000, 1'b0, ST_PAUSE2, O_IDLE);
    add_row(1'b0, 1'b1, 16'hD000, 1'b0, ST_PAUSE2, O_IDLE);
    add_row(1'b0, 1'b1, 16'hD000, 1'b0, ST_PAUSE2, O_IDLE);
    add_row(1'b0, 1'b0, 16'hD000, 1'b0, ST_FETCH1, O_F1);

    // Reset state
    #2;
    check_now("reset", ST_HALTED, O_IDLE);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vq[k]) begin
      @(negedge clk);
      run = vq[k].run; resume = vq[k].resume; ir = vq[k].ir; ben = vq[k].ben;
      @(posedge clk);
      #1;
      check_now($sformatf("row%0d", k), vq[k].st, vq[k].out);
      $display("row %0d ir=%04h run=%0b cont=%0b ben=%0b -> %s out=%07h",
               k, ir, run, resume, ben, vq[k].st.name(), sample());
    end

    // Asynchronous reset in the middle of an instruction fetch
    @(negedge clk);
    run = 1'b0; resume = 1'b0; ir = 16'h1042;
    @(posedge clk); #1;
    check_now("pre_reset_fetch2", ST_FETCH2, O_F2W);
    #2 rst_n = 1'b0;
    #1;
    check_now("async_reset", ST_HALTED, O_IDLE);
    checks++;
    if (dut.u_timer.count_reg !== 3'd0) begin
      errors++;
      $display("FAIL reset_counter: got %0d want 0", dut.u_timer.count_reg);
    end
    $display("async reset mid-FETCH2 -> %s mem_oe=%0b", dut.state_reg.name(), mem_oe);
    @(posedge clk); #1;
    check_now("reset_held", ST_HALTED, O_IDLE);

    // Release with Run low: must stay halted
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check_now("post_reset_idle", ST_HALTED, O_IDLE);
    end
    // First Run edge after reset starts fetching
    @(negedge clk);
    run = 1'b1;
    @(posedge clk); #1;
    check_now("restart", ST_FETCH1, O_F1);
    $display("restart after reset -> %s", dut.state_reg.name());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lc3_control_fsm.md
LC3_CONTROL_FSM -- requirements
Module: lc3_control_fsm

Interface
REQ-001 Parameter MEM_WAIT, default 2, SHALL set the number of cycles each memory read/write state is held (legal 1..7).
REQ-002 Clk  in  1  system clock; all state updates on rising edge.
REQ-003 Reset  in  1  asynchronous, active-low reset.
REQ-004 Run, Continue  in  1 each  start from HALTED / resume from PAUSE; level inputs, synchronized externally.
REQ-005 IR  in  16  instruction register contents; BEN  in  1  latched branch-enable.
REQ-006 LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  out  1 each  register load strobes.
REQ-007 GatePC, GateMDR, GateALU, GateMARMUX  out  1 each  bus drivers; at most one high per cycle.
REQ-008 PCselect, ALUKselect, ADDR2MUX  out  2 each; ADDR1MUX, DRMUXselect, SR1MUXselect, SR2MUXselect, MIO_EN  out  1 each.
REQ-009 Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  out  1 each  active-low memory strobes.

Function
REQ-010 States SHALL be: HALTED, FETCH1, FETCH2, FETCH3, DECODE, ADD, AND, NOT, BR, BR_TAKEN, JMP, JSR, JSR_R7, LDR_ADDR, LDR_READ, LDR_LOAD, STR_ADDR, STR_DATA, STR_WRITE, PAUSE1, PAUSE2.
REQ-011 Every output SHALL default to inactive (strobes 0, selects 0, Mem_* 1) in any state not listed as asserting it.
REQ-012 HALTED: Run=1 -> FETCH1, else stay.
REQ-013 FETCH1: GatePC, LD_MAR, PCselect=PC+1, LD_PC -> FETCH2.
REQ-014 FETCH2: MIO_EN, Mem_CE=Mem_OE=0, LD_MDR on final wait cycle only; held exactly MEM_WAIT cycles -> FETCH3.
REQ-015 FETCH3: GateMDR, LD_IR -> DECODE; DECODE: LD_BEN, branch on IR[15:12].
REQ-016 Opcode map: 0001 ADD, 0101 AND, 1001 NOT, 0000 BR, 1100 JMP, 0100 JSR, 0110 LDR, 0111 STR, 1101 PAUSE1; all others -> FETCH1 (no-op).
REQ-017 ADD/AND/NOT: SR1MUXselect=IR[8:6], SR2MUXselect=IR[5], ALUKselect per op, GateALU, LD_REG, LD_CC, DRMUXselect=IR[11:9] -> FETCH1.
REQ-018 BR: BEN=1 -> BR_TAKEN (ADDR1=PC, ADDR2=SEXT9, PCselect=adder, LD_PC) -> FETCH1; BEN=0 -> FETCH1.
REQ-019 JMP: ADDR1=SR1(IR[8:6]), ADDR2=zero, PCselect=adder, LD_PC -> FETCH1.
REQ-020 JSR: GatePC, DRMUXselect=R7, LD_REG -> JSR_R7: ADDR1=PC, ADDR2=SEXT11, PCselect=adder, LD_PC -> FETCH1.
REQ-021 LDR_ADDR: ADDR1=SR1, ADDR2=SEXT6, GateMARMUX, LD_MAR; LDR_READ as FETCH2; LDR_LOAD: GateMDR, LD_REG, LD_CC -> FETCH1.
REQ-022 STR_ADDR as LDR_ADDR; STR_DATA: SR1MUXselect=IR[11:9], ALUKselect=PASSA, GateALU, LD_MDR (MIO_EN=0); STR_WRITE: Mem_CE=Mem_WE=0 for MEM_WAIT cycles -> FETCH1.
REQ-023 PAUSE1: LD_LED for one cycle, wait Continue=1 -> PAUSE2; PAUSE2: wait Continue=0 -> FETCH1.
REQ-024 Wait counter SHALL be 3 bits, load MEM_WAIT-1 on entry to any memory state, decrement each cycle, exit at 0; no wraparound.
REQ-025 Mem_UB=Mem_LB=0 whenever Mem_CE=0.
REQ-026 Run deasserted after start SHALL NOT halt; only Reset returns to HALTED.

Reset
REQ-027 Reset=0 SHALL immediately force HALTED, counter 0, all outputs to REQ-011 defaults, including mid-memory-access.
REQ-028 First post-reset state change SHALL occur on the first Clk edge with Reset=1 and Run=1.

Structure
REQ-029 Shared package lc3_pkg SHALL hold the state enum, opcode constants, and select encodings: PCselect 00=PC+1/01=BUS/10=adder; ALUK 00=ADD/01=AND/10=NOT/11=PASSA; ADDR2 00=zero/01=SEXT6/10=SEXT9/11=SEXT11; ADDR1 0=PC/1=SR1; DRMUX 0=IR[11:9]/1=R7; SR1MUX 0=IR[11:9]/1=IR[8:6].
REQ-030 Wait counter SHALL be a sub-module mem_wait_timer; state register and next-state/output decode in lc3_control_fsm.

Verification
REQ-031 Reset low mid-FETCH2 -> next cycle HALTED, Mem_OE=1, all LD_* 0.
REQ-032 Run pulse, IR=0x1042 (ADD), MEM_WAIT=2 -> FETCH1,FETCH2x2,FETCH3,DECODE,ADD,FETCH1; LD_REG and LD_CC high only in ADD.
REQ-033 IR=0x0E05, BEN=1 -> BR_TAKEN with ADDR2MUX=10, PCselect=10; BEN=0 -> FETCH1 directly after BR.
REQ-034 IR=0x7242 (STR) -> STR_DATA LD_MDR with GateALU; Mem_WE=0 exactly MEM_WAIT cycles.
REQ-035 IR=0xD000 -> LD_LED one cycle; held Continue=1 keeps PAUSE2 until release.
REQ-036 IR=0x8000 (illegal) -> DECODE then FETCH1, no LD_REG/LD_PC asserted in between.
